lfsr_prng_gen: RTL and testbench

LFSR_PRNG_GEN -- requirements
Module: lfsr_prng_gen

---
 rtl/lfsr_prng_gen.sv | 172 +++++++++++++++++
 tb/tb_lfsr_prng_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen: Fibonacci LFSR keystream generator with seed load, warm-up
// and a valid/ready output word interface.
// Optional feature macro: LFSR_ZERO_GUARD_EN (all-zero seed replaced by
// RESET_SEED and flagged on o_zero_err). Without it o_zero_err is tied 0.
module lfsr_prng_gen #(
    parameter int               WIDTH      = 128,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(128'h8000_0000_0000_0000_0000_0000_0000_0043),
    parameter int               OUT_BITS   = 8,
    parameter int               WARMUP     = 16,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_seed_valid,
    input  logic [WIDTH-1:0]    i_seed,
    output logic                o_seed_ready,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [OUT_BITS-1:0] o_data,
    output logic [WIDTH-1:0]    o_state,
    output logic                o_busy,
    output logic                o_zero_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WARMUP, S_RUN} fsm_t;

    localparam logic [15:0] WARMUP_W  = 16'(WARMUP);
    localparam bit          NO_WARMUP = (WARMUP == 0);

    fsm_t                fsm_reg, fsm_next;
    logic [WIDTH-1:0]    lfsr_reg;
    logic [WIDTH-1:0]    seed_reg;
    logic [15:0]         cnt_reg, cnt_next;
    logic [OUT_BITS-1:0] data_reg;

    logic                seed_accept;
    logic                capture_seed;
    logic                do_load;
    logic                do_adv;
    logic                do_word;
    logic [WIDTH-1:0]    seed_eff;
    logic [WIDTH-1:0]    adv_src;
    logic [WIDTH-1:0]    adv_out;
    logic [OUT_BITS-1:0] adv_word;

`ifdef LFSR_ZERO_GUARD_EN
    logic zero_err_reg;

    assign seed_eff = (seed_reg == '0) ? RESET_SEED : seed_reg;

    // Sticky flag: set whenever an all-zero seed reaches LOAD.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            zero_err_reg <= 1'b0;
        else if (fsm_reg == S_LOAD && seed_reg == '0)
            zero_err_reg <= 1'b1;
    end

    assign o_zero_err = zero_err_reg;
`else
    assign seed_eff   = seed_reg;
    assign o_zero_err = 1'b0;
`endif

    assign seed_accept  = i_seed_valid && o_seed_ready;
    assign o_seed_ready = (fsm_reg == S_IDLE) || (fsm_reg == S_RUN);
    assign o_busy       = (fsm_reg == S_LOAD) || (fsm_reg == S_WARMUP);
    assign o_valid      = (fsm_reg == S_RUN);
    assign o_data       = data_reg;
    assign o_state      = lfsr_reg;

    // In LOAD with no warm-up the first word comes straight from the seed.
    assign adv_src = (fsm_reg == S_LOAD) ? seed_eff : lfsr_reg;

    // OUT_BITS unrolled LFSR steps; word bit i is the bit shifted out at step i.
    always_comb begin
        logic [WIDTH-1:0] s;
        s        = adv_src;
        adv_word = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            adv_word[i] = s[0];
            s           = {^(s & TAPS), s[WIDTH-1:1]};
        end
        adv_out = s;
    end

    // Next-state and datapath control decode.
    always_comb begin
        fsm_next     = fsm_reg;
        cnt_next     = cnt_reg;
        capture_seed = 1'b0;
        do_load      = 1'b0;
        do_adv       = 1'b0;
        do_word      = 1'b0;
        case (fsm_reg)
            S_IDLE: begin
                if (seed_accept) begin
                    capture_seed = 1'b1;
                    fsm_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                do_load  = 1'b1;
                cnt_next = WARMUP_W;
                if (NO_WARMUP) begin
                    do_adv   = 1'b1;
                    do_word  = 1'b1;
                    fsm_next = S_RUN;
                end else begin
                    fsm_next = S_WARMUP;
                end
            end
            S_WARMUP: begin
                do_adv   = 1'b1;
                cnt_next = cnt_reg - 16'd1;
                if (cnt_reg <= 16'd1) begin
                    do_word  = 1'b1;
                    fsm_next = S_RUN;
                end
            end
            S_RUN: begin
                // A new seed wins over a simultaneous consume; the word is dropped.
                if (seed_accept) begin
                    capture_seed = 1'b1;
                    fsm_next     = S_LOAD;
                end else if (i_ready) begin
                    do_adv  = 1'b1;
                    do_word = 1'b1;
                end
            end
            default: fsm_next = S_IDLE;
        endcase
    end

    // FSM state and warm-up counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fsm_reg <= S_IDLE;
            cnt_reg <= '0;
        end else begin
            fsm_reg <= fsm_next;
            cnt_reg <= cnt_next;
        end
    end

    // Seed capture register, holds the accepted seed until LOAD.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            seed_reg <= '0;
        else if (capture_seed)
            seed_reg <= i_seed;
    end

    // LFSR state: advance, load from seed, or hold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            lfsr_reg <= RESET_SEED;
        else if (do_adv)
            lfsr_reg <= adv_out;
        else if (do_load)
            lfsr_reg <= seed_eff;
    end

    // Output word register, only written when a word is presented.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            data_reg <= '0;
        else if (do_word)
            data_reg <= adv_word;
    end

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// tb_lfsr_prng_gen: directed tests for lfsr_prng_gen. Instance a uses the
// default parameters; instance b uses OUT_BITS=1, WARMUP=0.
module tb_lfsr_prng_gen;

    logic         clk;
    logic         reset;

    logic         a_seed_valid, a_seed_ready, a_valid, a_ready, a_busy, a_zero_err;
    logic [127:0] a_seed, a_state;
    logic [7:0]   a_data;

    logic         b_seed_valid, b_seed_ready, b_valid, b_ready, b_busy, b_zero_err;
    logic [127:0] b_seed, b_state;
    logic [0:0]   b_data;

    int checks = 0;
    int errors = 0;

    logic [127:0] m_state;
    logic [7:0]   m_word;

    lfsr_prng_gen dut_a (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_seed_valid (a_seed_valid),
        .i_seed       (a_seed),
        .o_seed_ready (a_seed_ready),
        .o_valid      (a_valid),
        .i_ready      (a_ready),
        .o_data       (a_data),
        .o_state      (a_state),
        .o_busy       (a_busy),
        .o_zero_err   (a_zero_err)
    );

    lfsr_prng_gen #(.OUT_BITS(1), .WARMUP(0)) dut_b (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_seed_valid (b_seed_valid),
        .i_seed       (b_seed),
        .o_seed_ready (b_seed_ready),
        .o_valid      (b_valid),
        .i_ready      (b_ready),
        .o_data       (b_data),
        .o_state      (b_state),
        .o_busy       (b_busy),
        .o_zero_err   (b_zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference: 8 steps of the x^127 taps {127,6,1,0} register.
    function automatic logic [127:0] ref_adv(input logic [127:0] s_in, output logic [7:0] w);
        logic [127:0] s;
        logic         fb;
        s = s_in;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[i] = s[0];
            fb   = s[127] ^ s[6] ^ s[1] ^ s[0];
            s    = {fb, s[127:1]};
        end
        return s;
    endfunction

    // Model of a fresh load: 16 discarded advances, the last one is the first word.
    task automatic model_load(input logic [127:0] seed);
        m_state = seed;
        for (int i = 0; i < 16; i++) m_state = ref_adv(m_state, m_word);
    endtask

    // Called at the negedge just after the accept edge (cycle 1); returns the
    // cycle index at which o_valid is first seen and the number of busy cycles.
    task automatic wait_first_valid(output int cyc, output int busy_cycles);
        cyc = 1;
        busy_cycles = 0;
        while (!a_valid && cyc < 60) begin
            if (a_busy) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", a_valid); end
        checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL rst_data got %0h want 0", a_data); end
        checks++; if (a_state !== 128'h1) begin errors++; $display("FAIL rst_state got %0h want 1", a_state); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h want 0", a_busy); end
        checks++; if (a_seed_ready !== 1'b1) begin errors++; $display("FAIL rst_seed_ready got %0h want 1", a_seed_ready); end
        checks++; if (a_zero_err !== 1'b0) begin errors++; $display("FAIL rst_zero_err got %0h want 0", a_zero_err); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %0h want 0", b_valid); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0h want 0", a_valid); end
        checks++; if (a_state !== 128'h1) begin errors++; $display("FAIL idle_state got %0h want 1", a_state); end
        $display("txn reset: state=%0h valid=%0b", a_state, a_valid);
    endtask

    task automatic test_first_word_nowarm;
        b_seed = 128'h1; b_seed_valid = 1'b1; b_ready = 1'b0;
        @(negedge clk);
        b_seed_valid = 1'b0;
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL b_load_valid got %0h want 0", b_valid); end
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL b_load_busy got %0h want 1", b_busy); end
        @(negedge clk);
        checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL b_first_valid got %0h want 1", b_valid); end
        checks++; if (b_data !== 1'b1) begin errors++; $display("FAIL b_first_data got %0h want 1", b_data); end
        checks++; if (b_state !== 128'h8000_0000_0000_0000_0000_0000_0000_0000) begin errors++; $display("FAIL b_first_state got %0h want 80000000000000000000000000000000", b_state); end
        b_ready = 1'b1;
        @(negedge clk);
        checks++; if (b_data !== 1'b0) begin errors++; $display("FAIL b_word2_data got %0h want 0", b_data); end
        checks++; if (b_state !== 128'hC000_0000_0000_0000_0000_0000_0000_0000) begin errors++; $display("FAIL b_word2_state got %0h want c0000000000000000000000000000000", b_state); end
        @(negedge clk);
        b_ready = 1'b0;
        checks++; if (b_state !== 128'hE000_0000_0000_0000_0000_0000_0000_0000) begin errors++; $display("FAIL b_word3_state got %0h want e0000000000000000000000000000000", b_state); end
        $display("txn nowarm: data=%0h state=%0h", b_data, b_state);
    endtask

    task automatic test_warmup_stream;
        int cyc, busy_cycles;
        a_seed = 128'h1; a_seed_valid = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        a_seed_valid = 1'b0;
        wait_first_valid(cyc, busy_cycles);
        checks++; if (cyc != 18) begin errors++; $display("FAIL warm_latency got %0d want 18", cyc); end
        checks++; if (busy_cycles != 17) begin errors++; $display("FAIL warm_busy got %0d want 17", busy_cycles); end
        model_load(128'h1);
        checks++; if (a_data !== m_word) begin errors++; $display("FAIL warm_first_data got %0h want %0h", a_data, m_word); end
        checks++; if (a_state !== m_state) begin errors++; $display("FAIL warm_first_state got %0h want %0h", a_state, m_state); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_state = ref_adv(m_state, m_word);
            checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h want 1", i, a_valid); end
            checks++; if (a_data !== m_word) begin errors++; $display("FAIL stream_data[%0d] got %0h want %0h", i, a_data, m_word); end
            checks++; if (a_state !== m_state) begin errors++; $display("FAIL stream_state[%0d] got %0h want %0h", i, a_state, m_state); end
            $display("txn stream %0d: data=%0h", i, a_data);
        end
        a_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [5:0] pat;
        pat = 6'b011001;   // applied LSB first: 1,0,0,1,1,0
        for (int i = 0; i < 6; i++) begin
            a_ready = pat[i];
            @(negedge clk);
            if (pat[i]) m_state = ref_adv(m_state, m_word);
            checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h want 1", i, a_valid); end
            checks++; if (a_data !== m_word) begin errors++; $display("FAIL bp_data[%0d] got %0h want %0h", i, a_data, m_word); end
            checks++; if (a_state !== m_state) begin errors++; $display("FAIL bp_state[%0d] got %0h want %0h", i, a_state, m_state); end
            $display("txn bp %0d ready=%0b data=%0h", i, pat[i], a_data);
        end
        a_ready = 1'b0;
    endtask

    task automatic test_reseed_priority;
        int cyc, busy_cycles;
        checks++; if (a_seed_ready !== 1'b1) begin errors++; $display("FAIL run_seed_ready got %0h want 1", a_seed_ready); end
        a_seed = 128'h5; a_seed_valid = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        a_seed_valid = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reseed_valid got %0h want 0", a_valid); end
        checks++; if (a_seed_ready !== 1'b0) begin errors++; $display("FAIL reseed_seed_ready got %0h want 0", a_seed_ready); end
        checks++; if (a_state !== m_state) begin errors++; $display("FAIL reseed_hold_state got %0h want %0h", a_state, m_state); end
        wait_first_valid(cyc, busy_cycles);
        checks++; if (cyc != 18) begin errors++; $display("FAIL reseed_latency got %0d want 18", cyc); end
        model_load(128'h5);
        checks++; if (a_data !== m_word) begin errors++; $display("FAIL reseed_first_data got %0h want %0h", a_data, m_word); end
        checks++; if (a_state !== m_state) begin errors++; $display("FAIL reseed_first_state got %0h want %0h", a_state, m_state); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_state = ref_adv(m_state, m_word);
            checks++; if (a_data !== m_word) begin errors++; $display("FAIL reseed_data[%0d] got %0h want %0h", i, a_data, m_word); end
            $display("txn reseed %0d: data=%0h", i, a_data);
        end
        a_ready = 1'b0;
    endtask

    task automatic test_zero_seed;
        int cyc, busy_cycles;
        logic exp_err;
        a_seed = '0; a_seed_valid = 1'b1; a_ready = 1'b0;
        @(negedge clk);
        a_seed_valid = 1'b0;
        wait_first_valid(cyc, busy_cycles);
        checks++; if (cyc != 18) begin errors++; $display("FAIL zero_latency got %0d want 18", cyc); end
`ifdef LFSR_ZERO_GUARD_EN
        model_load(128'h1);
        exp_err = 1'b1;
`else
        model_load(128'h0);
        exp_err = 1'b0;
`endif
        checks++; if (a_zero_err !== exp_err) begin errors++; $display("FAIL zero_err got %0h want %0h", a_zero_err, exp_err); end
        checks++; if (a_data !== m_word) begin errors++; $display("FAIL zero_first_data got %0h want %0h", a_data, m_word); end
        checks++; if (a_state !== m_state) begin errors++; $display("FAIL zero_first_state got %0h want %0h", a_state, m_state); end
        a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_state = ref_adv(m_state, m_word);
            checks++; if (a_data !== m_word) begin errors++; $display("FAIL zero_data[%0d] got %0h want %0h", i, a_data, m_word); end
            checks++; if (a_zero_err !== exp_err) begin errors++; $display("FAIL zero_err_sticky[%0d] got %0h want %0h", i, a_zero_err, exp_err); end
            $display("txn zero %0d: data=%0h", i, a_data);
        end
        a_ready = 1'b0;
    endtask

    task automatic test_reset_mid_warmup;
        a_seed = 128'h5; a_seed_valid = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        a_seed_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL midwarm_busy got %0h want 1", a_busy); end
        reset = 1'b1;
        #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h want 0", a_valid); end
        checks++; if (a_state !== 128'h1) begin errors++; $display("FAIL arst_state got %0h want 1", a_state); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0h want 0", a_busy); end
        checks++; if (a_seed_ready !== 1'b1) begin errors++; $display("FAIL arst_seed_ready got %0h want 1", a_seed_ready); end
        checks++; if (a_zero_err !== 1'b0) begin errors++; $display("FAIL arst_zero_err got %0h want 0", a_zero_err); end
        checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL arst_data got %0h want 0", a_data); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid[%0d] got %0h want 0", i, a_valid); end
        end
        checks++; if (a_state !== 128'h1) begin errors++; $display("FAIL post_rst_state got %0h want 1", a_state); end
        $display("txn reset mid-warmup: state=%0h valid=%0b", a_state, a_valid);
        a_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_seed_valid = 1'b0; a_seed = '0; a_ready = 1'b0;
        b_seed_valid = 1'b0; b_seed = '0; b_ready = 1'b0;
        test_reset;
        test_first_word_nowarm;
        test_warmup_stream;
        test_backpressure;
        test_reseed_priority;
        test_zero_seed;
        test_reset_mid_warmup;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
